// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for the FFJK stage: drives ENABLE/J/K for one cycle per repetition,
// then checks the fed-back Q on the following cycle and keeps error/command statistics.
module jk_cmd_sequencer #(
  parameter int CW = 8,
  parameter int RW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  input  logic [1:0]    CMD_OP,
  input  logic [RW-1:0] CMD_REP,
  output logic          CMD_READY,
  output logic          ENABLE,
  output logic          J,
  output logic          K,
  input  logic          Q_IN,
  output logic          DONE,
  output logic          ERR,
  output logic [CW-1:0] CMD_COUNT,
  output logic [CW-1:0] ERR_COUNT
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;

  state_t        state, state_nxt;
  logic [1:0]    op_q, op_nxt;
  logic [RW-1:0] rep_q, rep_nxt;
  logic          exp_q, exp_nxt;
  logic          en_nxt, j_nxt, k_nxt, done_nxt, err_nxt;
  logic [CW-1:0] cmd_cnt_nxt, err_cnt_nxt;

  assign CMD_READY = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      op_q      <= OP_HOLD;
      rep_q     <= '0;
      exp_q     <= 1'b0;
      ENABLE    <= 1'b0;
      J         <= 1'b0;
      K         <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      CMD_COUNT <= '0;
      ERR_COUNT <= '0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      rep_q     <= rep_nxt;
      exp_q     <= exp_nxt;
      ENABLE    <= en_nxt;
      J         <= j_nxt;
      K         <= k_nxt;
      DONE      <= done_nxt;
      ERR       <= err_nxt;
      CMD_COUNT <= cmd_cnt_nxt;
      ERR_COUNT <= err_cnt_nxt;
    end
  end

  // J/K encoding equals the op encoding, so the op is driven straight onto {J,K}.
  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    rep_nxt     = rep_q;
    exp_nxt     = exp_q;
    en_nxt      = 1'b0;
    j_nxt       = 1'b0;
    k_nxt       = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = ERR;
    cmd_cnt_nxt = CMD_COUNT;
    err_cnt_nxt = ERR_COUNT;
    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          op_nxt         = CMD_OP;
          rep_nxt        = (CMD_REP == '0) ? RW'(1) : CMD_REP;
          state_nxt      = DRIVE;
          en_nxt         = 1'b1;
          {j_nxt, k_nxt} = CMD_OP;
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
        case (op_q)
          OP_HOLD:  exp_nxt = Q_IN;
          OP_RESET: exp_nxt = 1'b0;
          OP_SET:   exp_nxt = 1'b1;
          default:  exp_nxt = ~Q_IN;
        endcase
      end
      CHECK: begin
        if (Q_IN != exp_q) begin
          err_nxt = 1'b1;
          if (ERR_COUNT != '1) err_cnt_nxt = ERR_COUNT + CW'(1);
        end
        rep_nxt = rep_q - RW'(1);
        if (rep_q > RW'(1)) begin
          state_nxt      = DRIVE;
          en_nxt         = 1'b1;
          {j_nxt, k_nxt} = op_q;
        end else begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          cmd_cnt_nxt = CMD_COUNT + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: behavioural FFJK in the loop (with a stuck-at-0 stub),
// per-command expectations queued at acceptance and checked on DONE.
module tb_jk_cmd_sequencer;
  localparam int CW = 8;
  localparam int RW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic [1:0]    CMD_OP = 2'b00;
  logic [RW-1:0] CMD_REP = '0;
  logic          CMD_READY, ENABLE, J, K, Q_IN, DONE, ERR;
  logic [CW-1:0] CMD_COUNT, ERR_COUNT;

  always #5 CLK = ~CLK;

  jk_cmd_sequencer #(.CW(CW), .RW(RW)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_REP(CMD_REP),
    .CMD_READY(CMD_READY), .ENABLE(ENABLE), .J(J), .K(K), .Q_IN(Q_IN),
    .DONE(DONE), .ERR(ERR), .CMD_COUNT(CMD_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  // JK flip-flop in the loop; stub forces the fed-back Q low
  logic ff_q = 1'b0;
  logic stub = 1'b0;
  always @(posedge CLK)
    if (ENABLE)
      case ({J, K})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
  assign Q_IN = stub ? 1'b0 : ff_q;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int            done_cyc;
    logic [CW-1:0] cmd_cnt;
    logic [CW-1:0] err_cnt;
    logic          err;
    logic          q;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [CW-1:0] m_cmd  = '0;
  logic [CW-1:0] m_errs = '0;
  logic          m_err  = 1'b0;
  logic          m_q    = 1'b0;

  always @(negedge CLK)
    if (DONE) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("done_cyc",  cyc,       mon_e.done_cyc);
        chk("cmd_count", CMD_COUNT, mon_e.cmd_cnt);
        chk("err_count", ERR_COUNT, mon_e.err_cnt);
        chk("err",       ERR,       mon_e.err);
        chk("q",         Q_IN,      mon_e.q);
      end
    end

  // Caller is just past a negedge; returns at the negedge of the first DRIVE cycle.
  task automatic send(input logic [1:0] op, input logic [RW-1:0] rep, input bit track,
                      output int acc);
    int   n, b;
    exp_t e;
    logic qin, expv;
    n = (rep == '0) ? 1 : int'(rep);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_REP = rep; b = 0;
    while (!CMD_READY && b < 100) begin @(negedge CLK); b++; end
    if (!CMD_READY) chk("accept_timeout", 0, 1);
    acc = cyc;
    @(negedge CLK);
    CMD_VALID = 1'b0; CMD_OP = 2'($urandom); CMD_REP = RW'($urandom);
    if (track) begin
      for (int i = 0; i < n; i++) begin
        qin = stub ? 1'b0 : m_q;
        case (op)
          2'b00:   begin expv = qin;   end
          2'b01:   begin expv = 1'b0;  m_q = 1'b0; end
          2'b10:   begin expv = 1'b1;  m_q = 1'b1; end
          default: begin expv = ~qin;  m_q = ~m_q; end
        endcase
        if ((stub ? 1'b0 : m_q) != expv) begin
          m_err = 1'b1;
          if (m_errs != '1) m_errs++;
        end
      end
      m_cmd++;
      e.done_cyc = acc + 1 + 2 * n;
      e.cmd_cnt  = m_cmd;
      e.err_cnt  = m_errs;
      e.err      = m_err;
      e.q        = stub ? 1'b0 : m_q;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((sb.size() != 0 || !CMD_READY) && b < 2000) begin @(negedge CLK); b++; end
    if (sb.size() != 0) chk("idle_timeout", sb.size(), 0);
    @(negedge CLK);
  endtask

  initial begin
    int a, a2, dc, b;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_ready",  CMD_READY, 1);
    chk("rst_en",     {ENABLE, J, K}, 0);
    chk("rst_done",   DONE, 0);
    chk("rst_err",    ERR, 0);
    chk("rst_cmdcnt", CMD_COUNT, 0);
    chk("rst_errcnt", ERR_COUNT, 0);

    // SET x1
    send(2'b10, 4'd1, 1, a);
    chk("set_drive", {CMD_READY, ENABLE, J, K}, 4'b0110);
    @(negedge CLK);
    chk("set_check_en", {ENABLE, J, K}, 0);
    chk("set_check_q",  Q_IN, 1);
    wait_idle();

    // TOGGLE x3 from Q=1
    send(2'b11, 4'd3, 1, a);
    for (int r = 0; r < 3; r++) begin
      chk("tog_drive", {ENABLE, J, K}, 3'b111);
      @(negedge CLK);
      chk("tog_check_en", ENABLE, 0);
      chk("tog_q", Q_IN, (r % 2 == 0) ? 0 : 1);
      @(negedge CLK);
    end
    wait_idle();

    // Q stuck low, SET x2: every check mismatches
    stub = 1'b1;
    send(2'b10, 4'd2, 1, a);
    @(negedge CLK);
    @(negedge CLK);
    chk("stub_err",    ERR, 1);
    chk("stub_errcnt", ERR_COUNT, 1);
    wait_idle();
    stub = 1'b0;

    // CMD_REP=0 behaves as 1
    send(2'b01, 4'd0, 1, a);
    wait_idle();

    // ERR_COUNT saturation
    stub = 1'b1;
    repeat (18) send(2'b10, 4'd15, 1, a);
    wait_idle();
    chk("errcnt_sat", ERR_COUNT, 8'hFF);
    stub = 1'b0;

    // CMD_COUNT wraps to 0
    repeat (256 - int'(m_cmd)) send(2'b00, 4'd1, 1, a);
    wait_idle();
    chk("cmdcnt_wrap", CMD_COUNT, 0);

    // Reset during DRIVE of TOGGLE x4 aborts without DONE
    send(2'b11, 4'd4, 0, a);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_ready",  CMD_READY, 1);
    chk("abort_en",     {ENABLE, J, K}, 0);
    chk("abort_done",   DONE, 0);
    chk("abort_cmdcnt", CMD_COUNT, 0);
    chk("abort_errcnt", ERR_COUNT, 0);
    chk("abort_err",    ERR, 0);
    m_cmd = '0; m_errs = '0; m_err = 1'b0; m_q = ff_q;
    repeat (8) begin
      @(negedge CLK);
      chk("abort_no_done", DONE, 0);
      chk("abort_idle_en", ENABLE, 0);
    end

    // Back-to-back: HOLD accepted in the DONE cycle of a SET
    send(2'b10, 4'd1, 1, a);
    b = 0;
    while (!DONE && b < 20) begin @(negedge CLK); b++; end
    chk("b2b_done_seen", DONE, 1);
    dc = cyc;
    send(2'b00, 4'd1, 1, a2);
    chk("b2b_accept", a2, dc);
    wait_idle();
    chk("final_cmdcnt", CMD_COUNT, 2);
    chk("final_err",    ERR, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
